// File: rtl/display_scroll_ctrl_pkg.sv
// Shared constants and state type for the calculator display scroll logic.
package display_scroll_ctrl_pkg;

   localparam int NUM_DIGITS = 11;
   localparam int WIN_DIGITS = 6;
   localparam int MAX_OFFSET = NUM_DIGITS - WIN_DIGITS;
   localparam int OFS_W      = 3;

   typedef enum logic [1:0] {
      MANUAL    = 2'd0,
      AUTO_UP   = 2'd1,
      AUTO_DOWN = 2'd2
   } scroll_state_t;

endpackage

// File: rtl/display_scroll_ctrl_btn_sync_edge.sv
// Button synchronizer followed by a registered rising-edge detector that
// emits a single-cycle pulse per press, however long the button is held.
module btn_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
      prev_d = sync_q[SYNC_STAGES-1];
      pulse  = sync_q[SYNC_STAGES-1] & ~prev_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

endmodule

// File: rtl/display_scroll_ctrl.sv
// Window-offset controller for the 6-of-11 digit display: manual stepping by
// buttons or an automatic bounce, always clamped to the significant digits.
module display_scroll_ctrl
   import display_scroll_ctrl_pkg::*;
#(
   parameter int AUTO_DIV    = 25000000,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        auto_en,
   input  logic        result_valid,
   input  logic [43:0] bcd_in,
   output logic [2:0]  count,
   output logic        more_hi,
   output logic        more_lo
);

   localparam int TICK_W = $clog2(AUTO_DIV);

   // result_valid is a fire-and-forget strobe: no ready, it is acted on in
   // the cycle it is high and overrides every other event in that cycle.
   logic up_pulse, down_pulse;

   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_up (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_in (btn_up),
      .pulse  (up_pulse)
   );

   btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_down (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_in (btn_down),
      .pulse  (down_pulse)
   );

   logic [3:0]       sig;
   logic [OFS_W-1:0] max_off;

   always_comb begin
      sig = 4'd1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (bcd_in[4*k +: 4] != 4'd0) sig = 4'(k + 1);
      end
      max_off = (sig > 4'(WIN_DIGITS)) ? OFS_W'(sig - 4'(WIN_DIGITS)) : '0;
      if (max_off > OFS_W'(MAX_OFFSET)) max_off = OFS_W'(MAX_OFFSET);
   end

   scroll_state_t     state_q, state_d;
   logic [OFS_W-1:0]  count_q, count_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic              tick;

   always_comb begin
      tick    = (state_q != MANUAL) && (tick_q == TICK_W'(AUTO_DIV - 1));
      state_d = state_q;
      count_d = count_q;
      tick_d  = (state_q == MANUAL || tick) ? '0 : tick_q + TICK_W'(1);

      if (result_valid) begin
         count_d = '0;
         tick_d  = '0;
         state_d = auto_en ? AUTO_UP : MANUAL;
      end else if (count_q > max_off) begin
         count_d = max_off;
      end else begin
         case (state_q)
            MANUAL: begin
               if (auto_en) begin
                  state_d = AUTO_UP;
                  tick_d  = '0;
               end else if (up_pulse && !down_pulse && count_q < max_off) begin
                  count_d = count_q + OFS_W'(1);
               end else if (down_pulse && !up_pulse && count_q != '0) begin
                  count_d = count_q - OFS_W'(1);
               end
            end
            AUTO_UP: begin
               if (!auto_en) begin
                  state_d = MANUAL;
                  tick_d  = '0;
               end else if (tick) begin
                  if (count_q < max_off) count_d = count_q + OFS_W'(1);
                  else                   state_d = AUTO_DOWN;
               end
            end
            AUTO_DOWN: begin
               if (!auto_en) begin
                  state_d = MANUAL;
                  tick_d  = '0;
               end else if (tick) begin
                  if (count_q != '0) count_d = count_q - OFS_W'(1);
                  else               state_d = AUTO_UP;
               end
            end
            default: state_d = MANUAL;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MANUAL;
         count_q <= '0;
         tick_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         tick_q  <= tick_d;
      end
   end

   always_comb begin
      count   = count_q;
      more_hi = (count_q < max_off);
      more_lo = (count_q != '0);
   end

endmodule

// File: tb/tb_display_scroll_ctrl.sv
// Directed bench for display_scroll_ctrl: scoreboard of {more_hi, more_lo, count}.
module tb_display_scroll_ctrl;

  logic        clk;
  logic        rst_n;
  logic        btn_up;
  logic        btn_down;
  logic        auto_en;
  logic        result_valid;
  logic [43:0] bcd_in;
  logic [2:0]  count;
  logic        more_hi;
  logic        more_lo;

  int checks   = 0;
  int failures = 0;
  logic [4:0] exp_q[$];

  display_scroll_ctrl #(.AUTO_DIV(4), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .auto_en      (auto_en),
    .result_valid (result_valid),
    .bcd_in       (bcd_in),
    .count        (count),
    .more_hi      (more_hi),
    .more_lo      (more_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic push_exp(input int c, input int moff);
    logic [2:0] c3;
    c3 = 3'(c);
    exp_q.push_back({(c < moff), (c != 0), c3});
  endtask

  task automatic check_out(input string tag);
    logic [4:0] exp_v;
    logic [4:0] obs_v;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s: scoreboard empty, observed=%b", tag, {more_hi, more_lo, count});
    end else begin
      exp_v = exp_q.pop_front();
      obs_v = {more_hi, more_lo, count};
      assert (obs_v === exp_v) else begin
        failures++;
        $error("FAIL %s: observed hi/lo/count=%b required=%b", tag, obs_v, exp_v);
      end
    end
  endtask

  task automatic press(input logic u, input logic d, input int hold);
    btn_up   = u;
    btn_down = d;
    repeat (hold) @(negedge clk);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int mc;
    bit mup;
    rst_n = 1'b0; btn_up = 1'b0; btn_down = 1'b0; auto_en = 1'b0;
    result_valid = 1'b0; bcd_in = '0;
    repeat (3) @(negedge clk);
    push_exp(0, 0); check_out("reset_state");

    // full 11-digit result, max_off = 5
    rst_n = 1'b1;
    bcd_in = 44'h123_4567_8901;
    @(negedge clk);
    push_exp(0, 5); check_out("full_idle");
    repeat (4) press(1'b1, 1'b0, 3);
    push_exp(4, 5); check_out("full_up4");

    // shrinking operand clamps on the next edge
    bcd_in = 44'h000_0000_0042;
    push_exp(0, 0);
    @(negedge clk);
    check_out("shrink_clamp");

    bcd_in = 44'h123_4567_8901;
    repeat (4) press(1'b1, 1'b0, 3);
    push_exp(4, 5); check_out("full_up4_again");
    #2 rst_n = 1'b0;
    push_exp(0, 5);
    #1 check_out("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_exp(0, 5); check_out("after_reset");

    // 7 significant digits, max_off = 1: latency and saturation
    bcd_in = 44'h000_0123_4567;
    @(negedge clk);
    btn_up = 1'b1;
    push_exp(0, 1);
    repeat (2) @(negedge clk);
    check_out("up_edge2");
    push_exp(1, 1);
    @(negedge clk);
    check_out("up_edge3");
    btn_up = 1'b0;
    repeat (4) @(negedge clk);
    press(1'b1, 1'b0, 3);
    push_exp(1, 1); check_out("up_saturate");
    press(1'b0, 1'b1, 3);
    push_exp(0, 1); check_out("down_step");
    press(1'b0, 1'b1, 3);
    push_exp(0, 1); check_out("down_saturate");
    press(1'b1, 1'b0, 100);
    push_exp(1, 1); check_out("held_one_step");
    press(1'b1, 1'b1, 3);
    push_exp(1, 1); check_out("both_buttons");

    // result_valid in the same cycle as an up pulse wins
    btn_up = 1'b1;
    repeat (2) @(negedge clk);
    result_valid = 1'b1;
    push_exp(0, 1);
    @(negedge clk);
    result_valid = 1'b0;
    check_out("rv_over_up");
    btn_up = 1'b0;
    repeat (4) @(negedge clk);
    push_exp(0, 1); check_out("rv_after");

    // auto bounce with AUTO_DIV = 4, max_off = 1
    bcd_in = 44'h000_0987_6543;
    @(negedge clk);
    auto_en = 1'b1;
    mc = 0;
    mup = 1'b1;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      if (j > 0 && j % 4 == 0) begin
        if (mup) begin
          if (mc < 1) mc++;
          else        mup = 1'b0;
        end else begin
          if (mc > 0) mc--;
          else        mup = 1'b1;
        end
      end
      push_exp(mc, 1); check_out("auto_seq");
      if (j == 6)  btn_up   = 1'b1;
      if (j == 10) btn_up   = 1'b0;
      if (j == 14) btn_down = 1'b1;
      if (j == 18) btn_down = 1'b0;
    end

    auto_en = 1'b0;
    for (int j = 0; j < 6; j++) begin
      push_exp(mc, 1);
      @(negedge clk);
      check_out("auto_freeze");
    end
    press(1'b0, 1'b1, 3);
    push_exp(0, 1); check_out("manual_resume_down");
    press(1'b1, 1'b0, 3);
    push_exp(1, 1); check_out("manual_resume_up");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
